// File: rtl/csr_hpm_counter_unit_pkg.sv
// Counter-bank CSR addresses, access ops and event config types.
// Shared by the counter bank top and its per-counter slice.
package csr_hpm_counter_unit_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'b01,
    CSR_RS = 2'b10,
    CSR_RC = 2'b11
  } csr_op_t;

  typedef enum logic [11:0] {
    MCOUNTINHIBIT = 12'h320,
    MHPMEVENT3    = 12'h323,
    MCYCLE        = 12'hB00,
    MINSTRET      = 12'hB02,
    MHPMCOUNTER3  = 12'hB03,
    MCYCLEH       = 12'hB80,
    MINSTRETH     = 12'hB82,
    MHPMCOUNTER3H = 12'hB83,
    CYCLE         = 12'hC00,
    INSTRET       = 12'hC02,
    HPMCOUNTER3   = 12'hC03,
    CYCLEH        = 12'hC80,
    INSTRETH      = 12'hC82,
    HPMCOUNTER3H  = 12'hC83
  } csr_reg_addr_t;

  localparam int HPM_SEL_W = 8;

  typedef enum logic [HPM_SEL_W-1:0] {
    HPM_EV_NONE        = 8'd0,
    HPM_EV_LOAD        = 8'd1,
    HPM_EV_STORE       = 8'd2,
    HPM_EV_BRANCH      = 8'd3,
    HPM_EV_MISPREDICT  = 8'd4,
    HPM_EV_ICACHE_MISS = 8'd5,
    HPM_EV_DCACHE_MISS = 8'd6,
    HPM_EV_LOAD_STALL  = 8'd7,
    HPM_EV_IF_STALL    = 8'd8,
    HPM_EV_EXCEPTION   = 8'd9,
    HPM_EV_INTERRUPT   = 8'd10,
    HPM_EV_MUL         = 8'd11,
    HPM_EV_DIV         = 8'd12,
    HPM_EV_JUMP        = 8'd13,
    HPM_EV_CSR         = 8'd14,
    HPM_EV_FENCE       = 8'd15,
    HPM_EV_WFI         = 8'd16
  } hpm_event_t;

  typedef struct packed {
    logic                 of;
    logic [HPM_SEL_W-1:0] sel;
  } hpm_event_cfg_t;

  // Slot k: 0 = cycle, 1 = instret, k>=2 = hpm(k-2).
  // Offset is also the mcountinhibit bit.
  function automatic logic [11:0] cnt_off(int k);
    if (k == 0) return 12'd0;
    if (k == 1) return 12'd2;
    return 12'(k + 1);
  endfunction

  function automatic logic [31:0] inh_mask(int n);
    return 32'h5 | (((32'h1 << n) - 32'h1) << 3);
  endfunction

  function automatic logic [31:0] csr_rmw(
    csr_op_t     op,
    logic [31:0] old,
    logic [31:0] wd
  );
    case (op)
      CSR_RS:  return old | wd;
      CSR_RC:  return old & ~wd;
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One free-running counter with half-word writes.
// Writes win over the increment; wrap flags a carry-out.
module hpm_counter #(
  parameter int COUNTER_W = 64,
  parameter int INC_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inhibit,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  input  logic [INC_W-1:0]     inc,
  output logic [COUNTER_W-1:0] value,
  output logic                 wrap
);

  logic [COUNTER_W:0] sum;
  logic               wr_any;

  assign wr_any = wr_lo | wr_hi;
  assign sum    = {1'b0, value} + (COUNTER_W+1)'(inc);
  assign wrap   = !inhibit && !wr_any && sum[COUNTER_W];

  // Counter state: half write, else increment unless inhibited.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (wr_any) begin
      if (wr_lo) value[31:0] <= wdata;
      if (wr_hi) value[COUNTER_W-1:32] <= wdata[COUNTER_W-33:0];
    end else if (!inhibit) begin
      value <= sum[COUNTER_W-1:0];
    end
  end

endmodule

// File: rtl/csr_hpm_counter_unit.sv
// Machine counter/HPM CSR bank: decode, RMW, event config,
// inhibit and registered access response.
module csr_hpm_counter_unit
  import csr_hpm_counter_unit_pkg::*;
#(
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_W    = 64,
  parameter int NUM_EVENTS   = 16,
  parameter int RETIRE_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    csr_req,
  input  logic [11:0]             csr_addr,
  input  csr_op_t                 csr_op,
  input  logic                    csr_wen,
  input  logic [31:0]             csr_wdata,
  output logic                    csr_done,
  output logic [31:0]             csr_rdata,
  output logic                    csr_illegal,
  input  logic [NUM_EVENTS-1:0]   events,
  input  logic [RETIRE_W-1:0]     retire_count,
  output logic [NUM_COUNTERS-1:0] overflow,
  output logic                    overflow_irq
);

  localparam int NC = NUM_COUNTERS + 2;
  localparam int EVENT_SEL_W = $clog2(NUM_EVENTS + 1);
  localparam logic [31:0] INH_MASK = inh_mask(NUM_COUNTERS);

  logic [NC-1:0]           hit_lo;
  logic [NC-1:0]           hit_hi;
  logic [NUM_COUNTERS-1:0] hit_evt;
  logic                    hit_inh;
  logic                    user_map;
  logic                    addr_ok;
  logic                    illegal;
  logic                    wr_ok;
  logic [31:0]             rd_val;
  logic [31:0]             wnew;
  logic [31:0]             inh_q;
  logic [COUNTER_W-1:0]    cnt_val [NC];
  logic [NC-1:0]           wrap;
  logic [NUM_COUNTERS-1:0] evt_hit;
  hpm_event_cfg_t          evt_cfg [NUM_COUNTERS];
  logic                    unused_wrap;

  // Address decode into counter halves, event regs, inhibit.
  always_comb begin
    hit_lo   = '0;
    hit_hi   = '0;
    hit_evt  = '0;
    user_map = 1'b0;
    hit_inh  = (csr_addr == MCOUNTINHIBIT);
    for (int k = 0; k < NC; k++) begin
      if (csr_addr == MCYCLE + cnt_off(k)) hit_lo[k] = 1'b1;
      if (csr_addr == MCYCLEH + cnt_off(k)) hit_hi[k] = 1'b1;
      if (csr_addr == CYCLE + cnt_off(k)) begin
        hit_lo[k] = 1'b1;
        user_map  = 1'b1;
      end
      if (csr_addr == CYCLEH + cnt_off(k)) begin
        hit_hi[k] = 1'b1;
        user_map  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_addr == MHPMEVENT3 + 12'(i)) hit_evt[i] = 1'b1;
    end
  end

  assign addr_ok = |{hit_lo, hit_hi, hit_evt, hit_inh};
  assign illegal = !addr_ok || (user_map && csr_wen);
  assign wr_ok   = csr_req && csr_wen && !illegal;

  // Pre-write read value of the addressed CSR.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NC; k++) begin
      if (hit_lo[k]) rd_val = cnt_val[k][31:0];
      if (hit_hi[k]) rd_val = 32'(cnt_val[k][COUNTER_W-1:32]);
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (hit_evt[i]) begin
        rd_val = {evt_cfg[i].of,
                  {(31-HPM_SEL_W){1'b0}},
                  evt_cfg[i].sel};
      end
    end
    if (hit_inh) rd_val = inh_q;
  end

  assign wnew = csr_rmw(csr_op, rd_val, csr_wdata);

  // Event select: sel k counts events[k-1]; others count nothing.
  always_comb begin
    evt_hit = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (evt_cfg[i].sel == HPM_SEL_W'(e + 1)) begin
          evt_hit[i] = evt_hit[i] | events[e];
        end
      end
    end
  end

  for (genvar k = 0; k < NC; k++) begin : g_cnt
    logic [RETIRE_W-1:0] inc;
    logic                inh;
    if (k == 0) begin : g_cy
      assign inc = RETIRE_W'(1);
    end else if (k == 1) begin : g_ir
      assign inc = retire_count;
    end else begin : g_hpm
      assign inc = RETIRE_W'(evt_hit[k-2]);
    end
    assign inh = inh_q[5'(cnt_off(k))];
    hpm_counter #(
      .COUNTER_W (COUNTER_W),
      .INC_W     (RETIRE_W)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inhibit (inh),
      .wr_lo   (wr_ok && hit_lo[k]),
      .wr_hi   (wr_ok && hit_hi[k]),
      .wdata   (wnew),
      .inc     (inc),
      .value   (cnt_val[k]),
      .wrap    (wrap[k])
    );
  end

  assign unused_wrap = ^wrap[1:0];

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_evt
    // Event config: writes win, otherwise a wrap sets sticky OF.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        evt_cfg[i] <= '0;
      end else if (wr_ok && hit_evt[i]) begin
        evt_cfg[i].of  <= wnew[31];
        evt_cfg[i].sel <= HPM_SEL_W'(wnew[EVENT_SEL_W-1:0]);
      end else if (wrap[i+2]) begin
        evt_cfg[i].of <= 1'b1;
      end
    end
    assign overflow[i] = evt_cfg[i].of;
  end

  // Inhibit register keeps only implemented bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_q <= '0;
    end else if (wr_ok && hit_inh) begin
      inh_q <= wnew & INH_MASK;
    end
  end

  // Registered response and overflow interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_done     <= 1'b0;
      csr_rdata    <= '0;
      csr_illegal  <= 1'b0;
      overflow_irq <= 1'b0;
    end else begin
      csr_done     <= csr_req;
      csr_illegal  <= csr_req && illegal;
      csr_rdata    <= (csr_req && addr_ok) ? rd_val : '0;
      overflow_irq <= |overflow;
    end
  end

endmodule

// File: tb/tb_csr_hpm_counter_unit.sv
// Directed bench for the counter bank: stimulus pushes
// expected responses, a negedge monitor pops and compares.
module tb_csr_hpm_counter_unit;
  import csr_hpm_counter_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req;
  logic [11:0] csr_addr;
  csr_op_t     csr_op;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic        csr_done;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [15:0] events;
  logic [1:0]  retire_count;
  logic [3:0]  overflow;
  logic        overflow_irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] rd_q [$];
  logic        il_q [$];
  logic        ck_q [$];
  int          cy_q [$];
  string       nm_q [$];

  csr_hpm_counter_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_req      (csr_req),
    .csr_addr     (csr_addr),
    .csr_op       (csr_op),
    .csr_wen      (csr_wen),
    .csr_wdata    (csr_wdata),
    .csr_done     (csr_done),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .events       (events),
    .retire_count (retire_count),
    .overflow     (overflow),
    .overflow_irq (overflow_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [11:0] a, input csr_op_t op,
                     input logic wen, input logic [31:0] wd,
                     input logic [31:0] er, input logic ei,
                     input logic ck, input string nm);
    csr_req   = 1'b1;
    csr_addr  = a;
    csr_op    = op;
    csr_wen   = wen;
    csr_wdata = wd;
    rd_q.push_back(er);
    il_q.push_back(ei);
    ck_q.push_back(ck);
    cy_q.push_back(cyc + 1);
    nm_q.push_back(nm);
    tick();
    csr_req = 1'b0;
    csr_wen = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] er,
                    input string nm);
    csr(a, CSR_RS, 1'b0, 32'h0, er, 1'b0, 1'b1, nm);
  endtask

  task automatic wr(input logic [11:0] a, input csr_op_t op,
                    input logic [31:0] wd, input logic [31:0] er,
                    input string nm);
    csr(a, op, 1'b1, wd, er, 1'b0, 1'b1, nm);
  endtask

  always @(negedge clk) begin
    if (csr_done) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got 1 want 0");
      end else begin
        automatic logic [31:0] er = rd_q.pop_front();
        automatic logic ei = il_q.pop_front();
        automatic logic ck = ck_q.pop_front();
        automatic int ec = cy_q.pop_front();
        automatic string nm = nm_q.pop_front();
        chk({nm, "_cycle"}, 64'(cyc), 64'(ec));
        chk({nm, "_illegal"}, 64'(csr_illegal), 64'(ei));
        if (ck) chk({nm, "_rdata"}, 64'(csr_rdata), 64'(er));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    csr_req = 1'b0;
    csr_addr = '0;
    csr_op = CSR_RW;
    csr_wen = 1'b0;
    csr_wdata = '0;
    events = '0;
    retire_count = '0;
    repeat (3) tick();
    chk("rst_done", 64'(csr_done), 0);
    chk("rst_rdata", 64'(csr_rdata), 0);
    chk("rst_illegal", 64'(csr_illegal), 0);
    chk("rst_irq", 64'(overflow_irq), 0);
    chk("rst_of", 64'(overflow), 0);
    rst_n = 1'b1;

    // Idle count and instret.
    repeat (10) tick();
    rd(MCYCLE, 10, "t1_mcycle");
    rd(MINSTRET, 0, "t1_minstret");
    rd(MCYCLEH, 0, "t1_mcycleh");
    retire_count = 2'd3;
    repeat (4) tick();
    retire_count = 2'd0;
    rd(MINSTRET, 12, "t1_minstret12");

    // Low-half carry into high half, then inhibit.
    wr(MCYCLE, CSR_RW, 32'hFFFF_FFFF, 18, "t2_wr_lo");
    wr(MCYCLEH, CSR_RW, 32'h0, 0, "t2_wr_hi");
    tick();
    rd(MCYCLEH, 1, "t2_carry_hi");
    rd(MCYCLE, 1, "t2_carry_lo");
    wr(MCOUNTINHIBIT, CSR_RS, 32'h1, 0, "t2_inh_set");
    rd(MCYCLE, 3, "t2_frozen_a");
    repeat (20) tick();
    rd(MCYCLE, 3, "t2_frozen_b");
    wr(MCOUNTINHIBIT, CSR_RC, 32'h1, 1, "t2_inh_clr");
    rd(MCYCLE, 3, "t2_resume");

    // Event counting and write collision.
    wr(MHPMEVENT3, CSR_RW, 32'd5, 0, "t3_sel");
    repeat (7) begin
      events = 16'h0018;
      tick();
      events = 16'h0000;
      tick();
    end
    events = 16'h0010;
    wr(MHPMCOUNTER3, CSR_RW, 32'd100, 7, "t3_collide");
    events = 16'h0000;
    rd(MHPMCOUNTER3, 100, "t3_after");
    wr(12'h324, CSR_RW, 32'd20, 0, "t3_sel_oor");
    events = 16'hFFEF;
    repeat (3) tick();
    events = 16'h0000;
    rd(12'hB04, 0, "t3_oor_cnt");
    rd(12'h324, 20, "t3_oor_sel");
    rd(12'hB05, 0, "t3_sel0_cnt");

    // Wrap sets sticky OF and the interrupt.
    wr(MHPMCOUNTER3, CSR_RW, 32'hFFFF_FFFF, 100, "t4_pre_lo");
    wr(MHPMCOUNTER3H, CSR_RW, 32'hFFFF_FFFF, 0, "t4_pre_hi");
    events = 16'h0010;
    tick();
    events = 16'h0000;
    chk("t4_of_set", 64'(overflow), 64'h1);
    chk("t4_irq_lag", 64'(overflow_irq), 0);
    tick();
    chk("t4_irq_set", 64'(overflow_irq), 1);
    rd(MHPMCOUNTER3, 0, "t4_wrapped_lo");
    rd(MHPMCOUNTER3H, 0, "t4_wrapped_hi");
    rd(MHPMEVENT3, 32'h8000_0005, "t4_evt_of");
    wr(MHPMEVENT3, CSR_RC, 32'h8000_0000, 32'h8000_0005,
       "t4_of_clr");
    chk("t4_of_clr", 64'(overflow), 0);
    tick();
    chk("t4_irq_clr", 64'(overflow_irq), 0);

    // Illegal and read-only accesses, inhibit mask.
    wr(MCOUNTINHIBIT, CSR_RS, 32'h1, 0, "t5_inh");
    csr(MCYCLE, CSR_RW, 1'b1, 32'd500, 0, 1'b0, 1'b0,
        "t5_wr500");
    csr(CYCLE, CSR_RW, 1'b1, 32'h1234, 500, 1'b1, 1'b1,
        "t5_ro_wr");
    rd(MCYCLE, 500, "t5_unchanged");
    rd(CYCLE, 500, "t5_ro_rd");
    csr(12'h7FF, CSR_RS, 1'b0, 32'h0, 0, 1'b1, 1'b1,
        "t5_bad_addr");
    wr(MCOUNTINHIBIT, CSR_RS, 32'hFFFF_FFFF, 1, "t5_inh_all");
    rd(MCOUNTINHIBIT, 32'h7D, "t5_inh_mask");
    rd(MINSTRET, 12, "t5_minstret");

    // Reset with a response on the outputs.
    wr(MHPMEVENT3, CSR_RW, 32'h8000_0005, 5, "t6_of_wr");
    chk("t6_of_set", 64'(overflow), 64'h1);
    tick();
    chk("t6_irq_set", 64'(overflow_irq), 1);
    csr_req = 1'b1;
    csr_addr = MCYCLE;
    tick();
    rst_n = 1'b0;
    csr_req = 1'b0;
    #1;
    chk("t6_done", 64'(csr_done), 0);
    chk("t6_rdata", 64'(csr_rdata), 0);
    chk("t6_of", 64'(overflow), 0);
    chk("t6_irq", 64'(overflow_irq), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    rd(MCYCLE, 0, "t6_mcycle");
    rd(MHPMCOUNTER3, 0, "t6_hpm3");
    rd(MHPMEVENT3, 0, "t6_evt3");
    rd(MCOUNTINHIBIT, 0, "t6_inh");
    rd(MINSTRET, 0, "t6_minstret");
    rd(MCYCLE, 5, "t6_mcycle_run");

    repeat (3) tick();
    chk("queue_drained", 64'(rd_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
